// File: rtl/mc_seq.sv
// mc_seq: multi-cycle instruction sequencer.
// It walks each instruction through fetch, decode, execute, memory and writeback.
// It owns the program counter, the exception level (exl) bit and the retired-instruction counter.
// A memory handshake that stalls too long latches a sticky timeout and parks the sequencer in HALT.
//
// Ports
//   clk, reset                : clock, asynchronous active-low reset
//   run                       : sequencing enable, sampled in IDLE and at instruction completion
//   instr_class[2:0]          : 0 ALU 1 LOAD 2 STORE 3 BRANCH 4 JUMP 5 MFC0 6 MTC0 7 ERET
//   br_taken                  : branch condition, used in EXEC
//   br_target, jmp_target, epc: next-pc sources
//   irq                       : level interrupt request
//   mem_ack                   : memory completion
//   mem_req, mem_we           : memory request / write qualifier
//   pc                        : current instruction address
//   ir_load, reg_w, cp0_w, exl_set : single-cycle strobes
//   state[2:0]                : current state encoding
//   retired                   : completed-instruction count (wraps)
//   timeout_err               : sticky memory-timeout flag
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | instruction fetch request, or interrupt entry check
// DECODE | one-cycle decode
// EXEC   | execute; BRANCH/MTC0/ERET complete here
// MEM    | data access; STORE completes on ack
// WB     | register writeback; completes ALU/LOAD/JUMP/MFC0
// TRAP   | interrupt entry: set exl, vector pc
// HALT   | memory timeout, left only by reset
module mc_seq #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] TRAP_PC     = WIDTH'(32'h0000_4180),
  parameter int               MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [2:0]       instr_class,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic [WIDTH-1:0] epc,
  input  logic             irq,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] pc,
  output logic             ir_load,
  output logic             reg_w,
  output logic             cp0_w,
  output logic             exl_set,
  output logic [2:0]       state,
  output logic [WIDTH-1:0] retired,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [2:0] C_ALU    = 3'd0;
  localparam logic [2:0] C_LOAD   = 3'd1;
  localparam logic [2:0] C_STORE  = 3'd2;
  localparam logic [2:0] C_BRANCH = 3'd3;
  localparam logic [2:0] C_JUMP   = 3'd4;
  localparam logic [2:0] C_MFC0   = 3'd5;
  localparam logic [2:0] C_MTC0   = 3'd6;
  localparam logic [2:0] C_ERET   = 3'd7;

  // Wait count only ever holds 0 .. MEM_TIMEOUT-1; the last no-ack cycle goes to HALT instead.
  localparam int             WW        = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WW-1:0]  WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] pc_q, pc_nxt;
  logic [WIDTH-1:0] ret_q, ret_nxt;
  logic [WW-1:0]    wait_q, wait_nxt;
  logic             exl_q, exl_nxt;
  logic             terr_q, terr_nxt;
  logic             done;
  logic [WIDTH-1:0] pc_plus4;

  assign pc_plus4 = pc_q + WIDTH'(4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ret_q   <= '0;
      wait_q  <= '0;
      exl_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      ret_q   <= ret_nxt;
      wait_q  <= wait_nxt;
      exl_q   <= exl_nxt;
      terr_q  <= terr_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    ret_nxt   = ret_q;
    wait_nxt  = '0;
    exl_nxt   = exl_q;
    terr_nxt  = terr_q;
    ir_load   = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_nxt = S_FETCH;

      S_FETCH: begin
        // Interrupts are only taken on a fresh fetch; an ack in that cycle is discarded.
        if (irq && !exl_q && (wait_q == '0)) begin
          state_nxt = S_TRAP;
        end else if (mem_ack) begin
          ir_load   = 1'b1;
          state_nxt = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_nxt = S_HALT;
          terr_nxt  = 1'b1;
        end else begin
          wait_nxt = wait_q + WW'(1);
        end
      end

      S_DECODE: state_nxt = S_EXEC;

      S_EXEC: begin
        case (instr_class)
          C_ALU, C_MFC0:   state_nxt = S_WB;
          C_LOAD, C_STORE: state_nxt = S_MEM;
          C_BRANCH: begin
            pc_nxt = br_taken ? br_target : pc_plus4;
            done   = 1'b1;
          end
          C_JUMP: begin
            pc_nxt    = jmp_target;
            state_nxt = S_WB;
          end
          C_MTC0: begin
            pc_nxt = pc_plus4;
            done   = 1'b1;
          end
          C_ERET: begin
            pc_nxt  = epc;
            exl_nxt = 1'b0;
            done    = 1'b1;
          end
          default: state_nxt = S_WB;
        endcase
      end

      S_MEM: begin
        if (mem_ack) begin
          if (instr_class == C_STORE) begin
            pc_nxt = pc_plus4;
            done   = 1'b1;
          end else begin
            state_nxt = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_nxt = S_HALT;
          terr_nxt  = 1'b1;
        end else begin
          wait_nxt = wait_q + WW'(1);
        end
      end

      S_WB: begin
        // JUMP already loaded its target in EXEC.
        if (instr_class != C_JUMP) pc_nxt = pc_plus4;
        done = 1'b1;
      end

      S_TRAP: begin
        exl_nxt   = 1'b1;
        pc_nxt    = TRAP_PC;
        state_nxt = S_FETCH;
      end

      S_HALT: state_nxt = S_HALT;

      default: state_nxt = S_IDLE;
    endcase

    if (done) begin
      ret_nxt   = ret_q + WIDTH'(1);
      state_nxt = run ? S_FETCH : S_IDLE;
    end
  end

  assign mem_req     = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem_we      = (state_q == S_MEM) && (instr_class == C_STORE);
  assign reg_w       = (state_q == S_WB);
  assign cp0_w       = (state_q == S_EXEC) && (instr_class == C_MTC0);
  assign exl_set     = (state_q == S_TRAP);
  assign state       = state_q;
  assign pc          = pc_q;
  assign retired     = ret_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mc_seq.sv
module tb_mc_seq;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd6, ST_HALT = 3'd7;
  localparam logic [2:0] ALU = 3'd0, LOAD = 3'd1, STORE = 3'd2, BRANCH = 3'd3;
  localparam logic [2:0] JUMP = 3'd4, MFC0 = 3'd5, MTC0 = 3'd6, ERET = 3'd7;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] TRP_PC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [2:0]  instr_class = 3'd0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0, jmp_target = '0, epc = '0;
  logic        irq = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, ir_load, reg_w, cp0_w, exl_set, timeout_err;
  logic [31:0] pc, retired;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  // Architectural reference state
  logic [31:0] pc_m  = RST_PC;
  logic [31:0] ret_m = '0;
  logic        exl_m = 1'b0;

  mc_seq dut (
    .clk(clk), .reset(reset), .run(run), .instr_class(instr_class),
    .br_taken(br_taken), .br_target(br_target), .jmp_target(jmp_target), .epc(epc),
    .irq(irq), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .pc(pc),
    .ir_load(ir_load), .reg_w(reg_w), .cp0_w(cp0_w), .exl_set(exl_set),
    .state(state), .retired(retired), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting from a fresh FETCH; fw/mw are no-ack cycles before the ack.
  task automatic do_instr(input logic [2:0] cls, input int fw, input int mw, input logic tk,
                          input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] ep,
                          input logic irq_l, input logic run_after);
    logic [31:0] exp_pc;
    bit is_mem, has_wb, done;
    int fcnt, mcnt, ncyc, nreq, nwe, nrw, ncw, nir;
    logic [2:0] prev;
    fcnt = 0; mcnt = 0; ncyc = 0; nreq = 0; nwe = 0; nrw = 0; ncw = 0; nir = 0; done = 0;

    is_mem = (cls == LOAD) || (cls == STORE);
    has_wb = (cls == ALU) || (cls == LOAD) || (cls == JUMP) || (cls == MFC0);
    case (cls)
      BRANCH:  exp_pc = tk ? bt : pc_m + 32'd4;
      JUMP:    exp_pc = jt;
      ERET:    exp_pc = ep;
      default: exp_pc = pc_m + 32'd4;
    endcase

    instr_class = cls; br_taken = tk; br_target = bt; jmp_target = jt; epc = ep;
    irq = irq_l; run = 1'b1;

    for (int c = 0; c < 80 && !done; c++) begin
      case (state)
        ST_FETCH: begin mem_ack = (fcnt == fw); fcnt++; end
        ST_MEM:   begin mem_ack = (mcnt == mw); mcnt++; end
        default:  mem_ack = 1'b0;
      endcase
      if (state == ST_DECODE) run = run_after;
      #1;
      nreq += mem_req ? 1 : 0;
      nwe  += mem_we  ? 1 : 0;
      nrw  += reg_w   ? 1 : 0;
      ncw  += cp0_w   ? 1 : 0;
      nir  += ir_load ? 1 : 0;
      ncyc++;
      prev = state;
      tick();
      if (state == ST_HALT || ((state == ST_FETCH || state == ST_IDLE) && prev != ST_FETCH))
        done = 1;
    end
    mem_ack = 1'b0;
    irq = 1'b0;

    chk("instr_done", 32'(done), 32'd1);
    chk("instr_cycles", ncyc, fw + 3 + (is_mem ? mw + 1 : 0) + (has_wb ? 1 : 0));
    chk("mem_req_cycles", nreq, fw + 1 + (is_mem ? mw + 1 : 0));
    chk("mem_we_cycles", nwe, (cls == STORE) ? mw + 1 : 0);
    chk("reg_w_pulses", nrw, has_wb ? 1 : 0);
    chk("cp0_w_pulses", ncw, (cls == MTC0) ? 1 : 0);
    chk("ir_load_pulses", nir, 1);

    pc_m  = exp_pc;
    ret_m = ret_m + 32'd1;
    if (cls == ERET) exl_m = 1'b0;

    chk("pc", pc, pc_m);
    chk("retired", retired, ret_m);
    chk("end_state", 32'(state), run_after ? 32'(ST_FETCH) : 32'(ST_IDLE));
    if (!run_after) begin
      tick();
      chk("idle_hold", 32'(state), 32'(ST_IDLE));
      run = 1'b1;
      tick();
      chk("idle_to_fetch", 32'(state), 32'(ST_FETCH));
    end
  endtask

  // Interrupt entry from a fresh FETCH with exl clear; a simultaneous ack must be dropped.
  task automatic do_trap(input logic ack_too);
    irq = 1'b1;
    mem_ack = ack_too;
    #1;
    chk("trap_no_irload", 32'(ir_load), 32'd0);
    tick();
    irq = 1'b0;
    mem_ack = 1'b0;
    chk("trap_state", 32'(state), 32'(ST_TRAP));
    chk("trap_exl_set", 32'(exl_set), 32'd1);
    chk("trap_no_req", 32'(mem_req), 32'd0);
    tick();
    chk("trap_ret_fetch", 32'(state), 32'(ST_FETCH));
    chk("trap_exl_set_off", 32'(exl_set), 32'd0);
    pc_m = TRP_PC;
    exl_m = 1'b1;
    chk("trap_pc", pc, pc_m);
    chk("trap_retired", retired, ret_m);
  endtask

  initial begin
    logic [2:0] cls;
    int cnt;

    // Reset values
    #3 reset = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_pc", pc, RST_PC);
    chk("rst_retired", retired, 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_strobes", {27'd0, mem_req, mem_we, reg_w, cp0_w, exl_set}, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_stay", 32'(state), 32'(ST_IDLE));
    run = 1'b1;
    tick();
    chk("idle_go", 32'(state), 32'(ST_FETCH));

    // ALU with immediate ack: 1,2,3,5,1
    instr_class = ALU;
    mem_ack = 1'b1;
    #1 chk("alu_irload", 32'(ir_load), 32'd1);
    tick();
    mem_ack = 1'b0;
    chk("alu_s2", 32'(state), 32'(ST_DECODE));
    tick(); chk("alu_s3", 32'(state), 32'(ST_EXEC));
    tick(); chk("alu_s5", 32'(state), 32'(ST_WB));
    chk("alu_regw", 32'(reg_w), 32'd1);
    tick(); chk("alu_s1", 32'(state), 32'(ST_FETCH));
    chk("alu_regw_off", 32'(reg_w), 32'd0);
    chk("alu_pc", pc, 32'h0000_3004);
    chk("alu_retired", retired, 32'd1);
    pc_m = 32'h0000_3004; ret_m = 32'd1;

    // LOAD with 3 wait cycles in MEM
    do_instr(LOAD, 0, 3, 0, '0, '0, '0, 0, 1);
    // Taken branch
    do_instr(BRANCH, 0, 0, 1, 32'h0000_3100, '0, '0, 0, 1);
    chk("branch_pc", pc, 32'h0000_3100);

    // Interrupt entry, masked irq, ERET, irq taken again
    do_trap(1'b1);
    do_instr(ALU, 1, 0, 0, '0, '0, '0, 1, 1);
    do_instr(ERET, 0, 0, 0, '0, '0, 32'h0000_3008, 1, 1);
    chk("eret_pc", pc, 32'h0000_3008);
    do_trap(1'b0);

    // pc+4 wrap
    do_instr(JUMP, 0, 0, 0, '0, 32'hFFFF_FFFC, '0, 0, 1);
    do_instr(ALU, 0, 0, 0, '0, '0, '0, 0, 1);
    chk("pc_wrap", pc, 32'd0);

    // Randomized instruction stream against the architectural model
    for (int i = 0; i < 40; i++) begin
      if (!exl_m && $urandom_range(0, 9) < 2) begin
        do_trap(1'($urandom_range(0, 1)));
      end else begin
        cls = 3'($urandom_range(0, 7));
        do_instr(cls, $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                 $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC,
                 $urandom() & 32'hFFFF_FFFC,
                 exl_m ? 1'($urandom_range(0, 1)) : 1'b0,
                 ($urandom_range(0, 3) != 0));
      end
    end

    // Asynchronous reset in the middle of a LOAD's MEM phase
    instr_class = LOAD;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick(); tick();
    chk("mem_state", 32'(state), 32'(ST_MEM));
    chk("mem_req_on", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'(ST_IDLE));
    chk("arst_pc", pc, RST_PC);
    chk("arst_retired", retired, 32'd0);
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    pc_m = RST_PC; ret_m = '0; exl_m = 1'b0;

    // Fetch timeout into HALT
    #1 reset = 1'b1;
    run = 1'b1;
    tick();
    chk("to_fetch", 32'(state), 32'(ST_FETCH));
    cnt = 0;
    for (int c = 0; c < 40 && state == ST_FETCH; c++) begin
      cnt += mem_req ? 1 : 0;
      tick();
    end
    chk("timeout_wait_cycles", cnt, 32'd15);
    chk("halt_state", 32'(state), 32'(ST_HALT));
    chk("halt_terr", 32'(timeout_err), 32'd1);
    chk("halt_mem_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b1;
    irq = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("halt_stuck", 32'(state), 32'(ST_HALT));
      chk("halt_strobes", {26'd0, mem_req, mem_we, reg_w, cp0_w, exl_set, ir_load}, 32'd0);
    end
    mem_ack = 1'b0;
    irq = 1'b0;
    reset = 1'b0;
    #1;
    chk("halt_reset_state", 32'(state), 32'(ST_IDLE));
    chk("halt_reset_terr", 32'(timeout_err), 32'd0);
    chk("halt_reset_pc", pc, RST_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
